// File: rtl/dmem_responder.sv
// dmem_responder
//   Data-memory responder for the M-stage port. Accepts one load/store at a
//   time, inserts WAIT_CYCLES wait states, commits stores per byte lane and
//   returns the (post-write) word with a one-cycle data_ok pulse. stall tells
//   the hazard unit a request is outstanding.
//
//   Parameters:
//     ADDR_W      word-index width, array depth 2**ADDR_W x 32 bits
//     WAIT_CYCLES wait states between acceptance and response (0..15)
//   Ports:
//     clk     clock, rising edge
//     rst     asynchronous active-low reset
//     en      request valid, fields held stable until data_ok
//     wen     byte enables, 4'b0000 = load
//     addr    byte address, index = addr[ADDR_W+1:2]
//     wdata   lane-aligned store data
//     rdata   word at addr, valid with data_ok
//     data_ok one-cycle response pulse
//     stall   en & ~data_ok
//     err     out-of-range flag, qualified by data_ok
//   Optional feature macro: DMEM_ERR_EN enables the address-range check;
//   without it upper address bits alias and err stays 0.
module dmem_responder #(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [3:0]  wen,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        data_ok,
  output logic        stall,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state;
  logic [3:0]  waitCnt;
  logic [31:0] mem [0:(2**ADDR_W)-1];

  logic [ADDR_W-1:0] wordIdx;
  logic [31:0]       mergedWord;
  logic              outOfRange;
  logic              enterResp;

  assign wordIdx = addr[ADDR_W+1:2];

`ifdef DMEM_ERR_EN
  assign outOfRange = |addr[31:ADDR_W+2];
  logic unusedAddrBits;
  assign unusedAddrBits = ^addr[1:0];
`else
  assign outOfRange = 1'b0;
  logic unusedAddrBits;
  assign unusedAddrBits = ^{addr[31:ADDR_W+2], addr[1:0]};
`endif

  // Request fields are held stable by the requester until data_ok, so the
  // commit reads them live instead of keeping a capture register.
  assign enterResp = en && (((state == IDLE) && (WAIT_CYCLES == 0)) ||
                            ((state == WAIT) && (waitCnt == '0)));

  // Post-write view of the addressed word; used for both commit and rdata.
  always_comb begin
    mergedWord = mem[wordIdx];
    for (int unsigned i = 0; i < 4; i++) begin
      if (wen[i]) mergedWord[8*i +: 8] = wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (enterResp && !outOfRange && (wen != '0)) begin
      mem[wordIdx] <= mergedWord;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      waitCnt <= '0;
      rdata   <= '0;
      data_ok <= 1'b0;
      err     <= 1'b0;
    end else begin
      data_ok <= 1'b0;
      err     <= 1'b0;
      case (state)
        IDLE: begin
          if (en) begin
            if (WAIT_CYCLES == 0) begin
              state   <= RESP;
              data_ok <= 1'b1;
              err     <= outOfRange;
              rdata   <= outOfRange ? '0 : mergedWord;
            end else begin
              state   <= WAIT;
              waitCnt <= 4'(WAIT_CYCLES - 1);
            end
          end
        end
        WAIT: begin
          if (!en) begin
            state   <= IDLE;
            waitCnt <= '0;
          end else if (waitCnt == '0) begin
            state   <= RESP;
            data_ok <= 1'b1;
            err     <= outOfRange;
            rdata   <= outOfRange ? '0 : mergedWord;
          end else begin
            waitCnt <= waitCnt - 4'd1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign stall = en & ~data_ok;

endmodule
